// File: rtl/cnc3_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnc3_meter_pkg
//  Description : Shared types and default sizes for the pulse width meter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnc3_meter_pkg;

    // Default prescaler counter width
    localparam int DEF_PRE_WIDTH = 16;
    // Default duration counter / result width
    localparam int DEF_WIDTH     = 16;

    // Measurement FSM: IDLE until the first edge, then tracks the current level
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } meter_state_e;

endpackage
`default_nettype wire

// File: rtl/pulse_width_meter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_width_meter_if
//  Description : Measurement input and result bundle of the pulse width meter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pulse_width_meter_if
    import cnc3_meter_pkg::*;
#(
    parameter int PRE_WIDTH = DEF_PRE_WIDTH,
    parameter int WIDTH     = DEF_WIDTH
);

    logic                 sig;
    logic [PRE_WIDTH-1:0] scale;
    logic [WIDTH-1:0]     high_len;
    logic [WIDTH-1:0]     low_len;
    logic                 high_valid;
    logic                 low_valid;
    logic                 ovf;

    // Side that supplies the level and tick scale and consumes results
    modport master (
        output sig,
        output scale,
        input  high_len,
        input  low_len,
        input  high_valid,
        input  low_valid,
        input  ovf
    );

    // The meter itself
    modport slave (
        input  sig,
        input  scale,
        output high_len,
        output low_len,
        output high_valid,
        output low_valid,
        output ovf
    );

endinterface
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides clk into ticks every scale+1 cycles. A restart makes
//                the current cycle phase 0 of a fresh tick period.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int PRE_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 aclr_n,
    input  wire logic                 sclr,
    input  wire logic                 restart,
    input  wire logic [PRE_WIDTH-1:0] scale,
    output logic                      tick
);

    logic [PRE_WIDTH-1:0] count;
    logic                 at_top;

    // >= rather than == so a scale lowered below the running count wraps at
    // the very next compare instead of running round the whole counter range.
    assign at_top = (count >= scale);

    // On restart the current cycle is phase 0: it only ticks when scale is 0.
    assign tick = restart ? (scale == '0) : at_top;

    // Free-running phase counter, wrapped at scale and realigned on restart
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            count <= '0;
        end else if (sclr) begin
            count <= '0;
        end else if (restart) begin
            count <= (scale == '0) ? '0 : PRE_WIDTH'(1);
        end else if (at_top) begin
            count <= '0;
        end else begin
            count <= count + PRE_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pulse_width_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_width_meter
//  Description : Measures high and low durations of an asynchronous level in
//                prescaled ticks, with strobed results and sticky overflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_width_meter
    import cnc3_meter_pkg::*;
#(
    parameter int PRE_WIDTH = DEF_PRE_WIDTH,
    parameter int WIDTH     = DEF_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          aclr_n,
    input  wire logic          sclr,
    pulse_width_meter_if.slave mif
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic         sync1;
    logic         sync2;
    logic         sync3;
    logic [2:0]   armed;
    logic         edge_seen;
    logic         rise;
    logic         fall;
    logic         tick;
    meter_state_e state;
    logic [WIDTH-1:0] count;

    // Two-flop synchronizer plus history flop; armed fills with ones so edges
    // are ignored until sync3 holds a real sample (a level already present at
    // reset release must not look like an edge).
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            armed <= '0;
        end else if (sclr) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            armed <= '0;
        end else begin
            sync1 <= mif.sig;
            sync2 <= sync1;
            sync3 <= sync2;
            armed <= {armed[1:0], 1'b1};
        end
    end

    assign edge_seen = armed[2] & (sync2 ^ sync3);
    assign rise      = edge_seen &  sync2;
    assign fall      = edge_seen & ~sync2;

    tick_prescaler #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .aclr_n  (aclr_n),
        .sclr    (sclr),
        .restart (edge_seen),
        .scale   (mif.scale),
        .tick    (tick)
    );

    // Measurement FSM with duration counter and registered results. On an
    // edge the old period's tick is dropped and the new period starts with
    // the restarted prescaler's phase-0 tick, giving floor(C/(scale+1)).
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state          <= IDLE;
            count          <= '0;
            mif.high_len   <= '0;
            mif.low_len    <= '0;
            mif.high_valid <= 1'b0;
            mif.low_valid  <= 1'b0;
            mif.ovf        <= 1'b0;
        end else if (sclr) begin
            state          <= IDLE;
            count          <= '0;
            mif.high_len   <= '0;
            mif.low_len    <= '0;
            mif.high_valid <= 1'b0;
            mif.low_valid  <= 1'b0;
            mif.ovf        <= 1'b0;
        end else begin
            mif.high_valid <= 1'b0;
            mif.low_valid  <= 1'b0;
            if (edge_seen) begin
                count <= WIDTH'(tick);
                case (state)
                    IDLE: begin
                        // First edge only aligns; the partial level is discarded
                        state <= rise ? HIGH : LOW;
                    end
                    HIGH: begin
                        if (fall) begin
                            mif.high_len   <= count;
                            mif.high_valid <= 1'b1;
                            state          <= LOW;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            mif.low_len   <= count;
                            mif.low_valid <= 1'b1;
                            state         <= HIGH;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else if ((state != IDLE) && tick && (count != ALL_ONES)) begin
                count <= count + WIDTH'(1);
                if (count == (ALL_ONES - WIDTH'(1))) begin
                    mif.ovf <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pulse_width_meter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_width_meter
//  Description : Self-checking bench for pulse_width_meter: table of level
//                durations against hand-derived tick counts, plus reset,
//                power-up and saturation sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_width_meter;

    typedef struct {
        int          scale;
        int          hi_cyc;
        int          lo_cyc;
        logic [15:0] exp_hi;
        logic [15:0] exp_lo;
    } vec_t;

    typedef struct {
        bit          is_high;
        logic [15:0] len;
    } exp_t;

    logic clk;
    logic aclr_n;
    logic sclr;
    logic sclr2;

    int checks;
    int errors;

    exp_t sb[$];
    vec_t vecs[6];

    pulse_width_meter_if #(.PRE_WIDTH(16), .WIDTH(16)) m1 ();
    pulse_width_meter_if #(.PRE_WIDTH(16), .WIDTH(4))  m2 ();

    pulse_width_meter #(.PRE_WIDTH(16), .WIDTH(16)) dut (
        .clk    (clk),
        .aclr_n (aclr_n),
        .sclr   (sclr),
        .mif    (m1)
    );

    pulse_width_meter #(.PRE_WIDTH(16), .WIDTH(4)) dut_w4 (
        .clk    (clk),
        .aclr_n (aclr_n),
        .sclr   (sclr2),
        .mif    (m2)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Compare any strobe of the main DUT against the scoreboard head
    task automatic monitor();
        exp_t        e;
        logic        got_high;
        logic [15:0] got_len;
        if (m1.high_valid === 1'b1 || m1.low_valid === 1'b1) begin
            checks++;
            got_high = m1.high_valid & ~m1.low_valid;
            got_len  = got_high ? m1.high_len : m1.low_len;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected high_valid=%0b low_valid=%0b len=%0d",
                         m1.high_valid, m1.low_valid, got_len);
            end else begin
                e = sb.pop_front();
                if ((m1.high_valid & m1.low_valid) || (got_high != e.is_high) || (got_len != e.len)) begin
                    errors++;
                    $display("FAIL strobe: got high=%0b len=%0d, expected high=%0b len=%0d",
                             got_high, got_len, e.is_high, e.len);
                end
            end
        end
    endtask

    // Advance n cycles: sample at negedge, return 1 unit after posedge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            monitor();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit is_high, input logic [15:0] len);
        exp_t e;
        e.is_high = is_high;
        e.len     = len;
        sb.push_back(e);
    endtask

    // Wait (bounded) for every expected strobe to have been seen
    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        step(4);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        bit found;
        checks = 0;
        errors = 0;

        //            scale  high   low    high_len low_len
        vecs[0] = '{0,      100,   100,   16'd100, 16'd100};
        vecs[1] = '{3,      11,    12,    16'd2,   16'd3};
        vecs[2] = '{1,      7,     8,     16'd3,   16'd4};
        vecs[3] = '{4,      25,    9,     16'd5,   16'd1};
        vecs[4] = '{0,      3,     2,     16'd3,   16'd2};
        vecs[5] = '{7199,   36000, 7200,  16'd5,   16'd1};

        aclr_n   = 1'b1;
        sclr     = 1'b0;
        sclr2    = 1'b0;
        m1.sig   = 1'b0;
        m1.scale = '0;
        m2.sig   = 1'b0;
        m2.scale = '0;

        // Reset state
        step(1);
        aclr_n = 1'b0;
        step(2);
        check("reset_high_len",   m1.high_len,   0);
        check("reset_low_len",    m1.low_len,    0);
        check("reset_high_valid", m1.high_valid, 0);
        check("reset_low_valid",  m1.low_valid,  0);
        check("reset_ovf",        m1.ovf,        0);
        aclr_n = 1'b1;
        step(5);

        // Table: clear, rise from IDLE, high for hi_cyc, low for lo_cyc, rise
        foreach (vecs[k]) begin
            sclr   = 1'b1;
            m1.sig = 1'b0;
            step(5);
            sclr = 1'b0;
            step(1);
            check("sclr_high_len", m1.high_len, 0);
            check("sclr_low_len",  m1.low_len,  0);
            m1.scale = 16'(vecs[k].scale);
            step(2);
            m1.sig = 1'b1;
            step(vecs[k].hi_cyc);
            push(1'b1, vecs[k].exp_hi);
            m1.sig = 1'b0;
            step(vecs[k].lo_cyc);
            push(1'b0, vecs[k].exp_lo);
            m1.sig = 1'b1;
            drain("vec_drain", 40);
            check("vec_ovf", m1.ovf, 0);
        end

        // Power-up with sig already high: the fall gives nothing, the rise gives low only
        m1.scale = '0;
        m1.sig   = 1'b1;
        aclr_n   = 1'b0;
        step(3);
        aclr_n = 1'b1;
        step(10);
        m1.sig = 1'b0;
        step(25);
        push(1'b0, 16'd25);
        m1.sig = 1'b1;
        drain("powerup_drain", 20);
        check("powerup_low_len",  m1.low_len,  25);
        check("powerup_high_len", m1.high_len, 0);

        // Asynchronous reset mid-HIGH: everything clears, next fall is the IDLE path
        step(20);
        #2;
        aclr_n = 1'b0;
        #1;
        check("midreset_high_len",   m1.high_len,   0);
        check("midreset_low_len",    m1.low_len,    0);
        check("midreset_high_valid", m1.high_valid, 0);
        check("midreset_low_valid",  m1.low_valid,  0);
        check("midreset_ovf",        m1.ovf,        0);
        step(3);
        aclr_n = 1'b1;
        step(10);
        m1.sig = 1'b0;
        step(30);
        push(1'b0, 16'd30);
        m1.sig = 1'b1;
        drain("midreset_drain", 20);

        // WIDTH=4 saturation and sticky overflow
        m2.scale = '0;
        step(5);
        m2.sig = 1'b1;
        step(40);
        m2.sig = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1);
            if (m2.high_valid === 1'b1) found = 1'b1;
        end
        check("w4_high_valid", found, 1);
        check("w4_high_len",   m2.high_len, 15);
        check("w4_ovf",        m2.ovf, 1);
        check("w4_low_valid",  m2.low_valid, 0);
        m2.scale = 16'd15;
        step(20);
        check("w4_ovf_sticky", m2.ovf, 1);
        sclr2 = 1'b1;
        step(1);
        sclr2 = 1'b0;
        step(1);
        check("w4_sclr_ovf",      m2.ovf, 0);
        check("w4_sclr_high_len", m2.high_len, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
